// File: rtl/uart_pkg.sv
// Shared UART line-level constants: control characters, printable range and tx_line states.
package uart_pkg;

   localparam logic [7:0] CHAR_NUL = 8'h00;
   localparam logic [7:0] CHAR_LF  = 8'h0A;
   localparam logic [7:0] CHAR_CR  = 8'h0D;

   localparam logic [7:0] PRINT_MIN_DEF = 8'h20;
   localparam logic [7:0] PRINT_MAX_DEF = 8'h7E;

   typedef enum logic [9:0] {
      ST_IDLE    = 10'b00_0000_0001,
      ST_FETCH   = 10'b00_0000_0010,
      ST_CHECK   = 10'b00_0000_0100,
      ST_SEND    = 10'b00_0000_1000,
      ST_WAIT    = 10'b00_0001_0000,
      ST_SEND_CR = 10'b00_0010_0000,
      ST_WAIT_CR = 10'b00_0100_0000,
      ST_SEND_LF = 10'b00_1000_0000,
      ST_WAIT_LF = 10'b01_0000_0000,
      ST_DONE    = 10'b10_0000_0000
   } tx_line_state_e;

   function automatic logic is_printable(input logic [7:0] c,
                                         input logic [7:0] lo,
                                         input logic [7:0] hi);
      return (c >= lo) && (c <= hi);
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector on a level input; the history register resets to 1 so a level
// held high through reset never reads as an edge. Combinational edge, one register of history.
module rise_detect (
   input  logic clock,
   input  logic reset,
   input  logic level_i,
   output logic edge_o
);

   logic last_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         last_q <= 1'b1;
      end else begin
         last_q <= level_i;
      end
   end

   assign edge_o = level_i && !last_q;

endmodule

// File: rtl/tx_line.sv
// Streams a NUL-terminated line from line RAM to the UART byte engine, then CR/LF.
// One byte in flight; each byte waits for the UART's tx_done rising edge before the next fetch.
module tx_line
   import uart_pkg::*;
#(
   parameter bit         APPEND_CR = 1'b1,
   parameter logic [7:0] PRINT_MIN = PRINT_MIN_DEF,
   parameter logic [7:0] PRINT_MAX = PRINT_MAX_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start_i,
   input  logic [7:0] start_addr_i,
   output logic [7:0] addr_o,
   input  logic [7:0] rd_data_i,
   output logic [7:0] tx_data_o,
   output logic       tx_start_o,
   input  logic       tx_done_i,
   output logic       busy_o,
   output logic       tx_line_done_o,
   output logic       truncated_o
);

   tx_line_state_e state_q, state_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] base_q, base_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_start_q, tx_start_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       trunc_q, trunc_d;

   logic           tx_done_edge;
   logic           edge_ok;
   logic [7:0]     addr_inc;
   logic           wrap;
   logic           printable;
   tx_line_state_e eol_st;

   rise_detect u_done_edge (
      .clock   (clock),
      .reset   (reset),
      .level_i (tx_done_i),
      .edge_o  (tx_done_edge)
   );

   // An edge coinciding with our own tx_start pulse belongs to the previous byte.
   assign edge_ok   = tx_done_edge && !tx_start_q;
   assign addr_inc  = addr_q + 8'd1;
   assign wrap      = (addr_inc == base_q);
   assign printable = is_printable(rd_data_i, PRINT_MIN, PRINT_MAX);
   assign eol_st    = APPEND_CR ? ST_SEND_CR : ST_SEND_LF;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= 8'd0;
         base_q     <= 8'd0;
         tx_data_q  <= 8'd0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         trunc_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         base_q     <= base_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         trunc_q    <= trunc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start_i) state_d = ST_FETCH;
         ST_FETCH:   state_d = ST_CHECK;
         ST_CHECK: begin
            if (rd_data_i == CHAR_NUL)  state_d = eol_st;
            else if (!printable)        state_d = wrap ? eol_st : ST_FETCH;
            else                        state_d = ST_WAIT;
         end
         ST_WAIT:    if (edge_ok) state_d = wrap ? eol_st : ST_FETCH;
         ST_SEND_CR: state_d = ST_WAIT_CR;
         ST_WAIT_CR: if (edge_ok) state_d = ST_SEND_LF;
         ST_SEND_LF: state_d = ST_WAIT_LF;
         ST_WAIT_LF: if (edge_ok) state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      addr_d     = addr_q;
      base_d     = base_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      trunc_d    = trunc_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               addr_d  = start_addr_i;
               base_d  = start_addr_i;
               busy_d  = 1'b1;
               trunc_d = 1'b0;
            end
         end
         ST_CHECK: begin
            if (rd_data_i == CHAR_NUL) begin
               // line ending handled by the next state
            end else if (!printable) begin
               if (wrap) trunc_d = 1'b1;
               else      addr_d  = addr_inc;
            end else begin
               tx_data_d  = rd_data_i;
               tx_start_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (edge_ok) begin
               if (wrap) trunc_d = 1'b1;
               else      addr_d  = addr_inc;
            end
         end
         ST_SEND_CR: begin
            tx_data_d  = CHAR_CR;
            tx_start_d = 1'b1;
         end
         ST_SEND_LF: begin
            tx_data_d  = CHAR_LF;
            tx_start_d = 1'b1;
         end
         ST_DONE: begin
            done_d = 1'b1;
            busy_d = 1'b0;
         end
         default: ;
      endcase
   end

   assign addr_o         = addr_q;
   assign tx_data_o      = tx_data_q;
   assign tx_start_o     = tx_start_q;
   assign busy_o         = busy_q;
   assign tx_line_done_o = done_q;
   assign truncated_o    = trunc_q;

endmodule

// File: tb/tb_tx_line.sv
// Scoreboard bench for tx_line: a string-walking reference model fills expectation queues,
// UART models ack each byte after a random delay, and a monitor pops on every tx_start / tx_line_done.
module tb_tx_line;
   import uart_pkg::*;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset;
   logic       start0, start1;
   logic [7:0] sa0, sa1, addr0, addr1, rd0, rd1, txd0, txd1;
   logic       txs0, txs1, txdone0, txdone1;
   logic       busy0, busy1, lnd0, lnd1, trn0, trn1;

   logic [7:0] ram [256];

   typedef struct {
      int         id;
      logic [7:0] b;
   } ent_t;

   ent_t exp_q[$];
   ent_t done_q[$];

   int n_pass  = 0;
   int n_total = 0;
   int uart_lo = 1;
   int uart_hi = 6;

   tx_line #(.APPEND_CR(1'b1)) dut (
      .clock(clock), .reset(reset), .start_i(start0), .start_addr_i(sa0),
      .addr_o(addr0), .rd_data_i(rd0), .tx_data_o(txd0), .tx_start_o(txs0),
      .tx_done_i(txdone0), .busy_o(busy0), .tx_line_done_o(lnd0), .truncated_o(trn0)
   );

   tx_line #(.APPEND_CR(1'b0)) dut_lf (
      .clock(clock), .reset(reset), .start_i(start1), .start_addr_i(sa1),
      .addr_o(addr1), .rd_data_i(rd1), .tx_data_o(txd1), .tx_start_o(txs1),
      .tx_done_i(txdone1), .busy_o(busy1), .tx_line_done_o(lnd1), .truncated_o(trn1)
   );

   // Registered-read line RAM, one read port per DUT.
   always @(posedge clock) begin
      rd0 <= ram[addr0];
      rd1 <= ram[addr1];
   end

   task automatic chk(input string nm, input int act, input int expv);
      n_total++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
   endtask

   // UART byte engines: drop tx_done on tx_start, raise it after a random delay.
   initial begin : uart0
      logic [7:0] lat;
      int n;
      bit ab;
      txdone0 = 1'b1;
      forever begin
         @(negedge clock);
         if (txs0) begin
            lat = txd0;
            txdone0 = 1'b0;
            n = $urandom_range(uart_hi, uart_lo);
            ab = 0;
            for (int k = 0; k < n; k++) begin
               @(negedge clock);
               if (reset) ab = 1;
            end
            if (!ab) chk("tx_data_stable0", int'(txd0), int'(lat));
            txdone0 = 1'b1;
         end
      end
   end

   initial begin : uart1
      logic [7:0] lat;
      int n;
      bit ab;
      txdone1 = 1'b1;
      forever begin
         @(negedge clock);
         if (txs1) begin
            lat = txd1;
            txdone1 = 1'b0;
            n = $urandom_range(uart_hi, uart_lo);
            ab = 0;
            for (int k = 0; k < n; k++) begin
               @(negedge clock);
               if (reset) ab = 1;
            end
            if (!ab) chk("tx_data_stable1", int'(txd1), int'(lat));
            txdone1 = 1'b1;
         end
      end
   end

   task automatic pop_tx(input int id, input logic [7:0] b);
      ent_t e;
      if (exp_q.size() == 0) begin
         chk("tx_start_expected", exp_q.size(), 1);
      end else begin
         e = exp_q.pop_front();
         chk("tx_dut_id", id, e.id);
         chk("tx_byte", int'(b), int'(e.b));
      end
   endtask

   task automatic pop_done(input int id, input logic t, input logic bsy);
      ent_t e;
      if (done_q.size() == 0) begin
         chk("line_done_expected", done_q.size(), 1);
      end else begin
         e = done_q.pop_front();
         chk("done_dut_id", id, e.id);
         chk("truncated", int'(t), int'(e.b));
         chk("busy_low_at_done", int'(bsy), 0);
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clock);
         if (txs0) pop_tx(0, txd0);
         if (txs1) pop_tx(1, txd1);
         if (lnd0) pop_done(0, trn0, busy0);
         if (lnd1) pop_done(1, trn1, busy1);
      end
   end

   // Reference: walk the string as stored, keep printable bytes, stop at NUL or after 256 bytes.
   task automatic expect_line(input int id, input logic [7:0] sa, input bit crlf);
      logic [7:0] a, c;
      bit found;
      found = 0;
      for (int i = 0; i < 256; i++) begin
         a = sa + 8'(i);
         c = ram[a];
         if (c == 8'h00) begin
            found = 1;
            break;
         end
         if (c >= 8'h20 && c <= 8'h7E) exp_q.push_back('{id, c});
      end
      if (crlf) exp_q.push_back('{id, 8'h0D});
      exp_q.push_back('{id, 8'h0A});
      done_q.push_back('{id, found ? 8'd0 : 8'd1});
   endtask

   task automatic issue_start(input int id, input logic [7:0] sa);
      @(negedge clock);
      if (id == 0) begin start0 = 1'b1; sa0 = sa; end
      else         begin start1 = 1'b1; sa1 = sa; end
      @(negedge clock);
      start0 = 1'b0;
      start1 = 1'b0;
      sa0 = 8'($urandom);
      sa1 = 8'($urandom);
      chk("busy_after_start", int'(id == 0 ? busy0 : busy1), 1);
   endtask

   task automatic wait_done(input int id);
      int cyc;
      cyc = 0;
      while (!(id == 0 ? lnd0 : lnd1) && cyc < 20000) begin
         @(negedge clock);
         cyc++;
      end
      chk("line_done_in_time", int'(cyc < 20000), 1);
      @(negedge clock);
      chk("pending_bytes", exp_q.size(), 0);
      chk("pending_done", done_q.size(), 0);
   endtask

   task automatic run_line(input int id, input logic [7:0] sa);
      expect_line(id, sa, id == 0);
      issue_start(id, sa);
      wait_done(id);
   endtask

   task automatic wait_uart_idle;
      int cyc;
      cyc = 0;
      while (!(txdone0 && txdone1) && cyc < 100) begin
         @(negedge clock);
         cyc++;
      end
      chk("uart_idle", int'(txdone0 && txdone1), 1);
      repeat (3) @(negedge clock);
   endtask

   initial begin : main
      int cyc, len;
      logic [7:0] sa;
      start0 = 1'b0; start1 = 1'b0; sa0 = 8'h00; sa1 = 8'h00;
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_addr", int'(addr0), 0);
      chk("rst_tx_data", int'(txd0), 0);
      chk("rst_tx_start", int'(txs0), 0);
      chk("rst_busy", int'(busy0), 0);
      chk("rst_line_done", int'(lnd0), 0);
      chk("rst_truncated", int'(trn0), 0);
      chk("rst_busy_lf", int'(busy1), 0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      ram[8'h10] = "H"; ram[8'h11] = "I"; ram[8'h12] = 8'h00;
      run_line(0, 8'h10);

      ram[8'h40] = 8'h00;
      run_line(0, 8'h40);
      chk("empty_addr_stays", int'(addr0), 8'h40);

      ram[8'h00] = "A"; ram[8'h01] = 8'h07; ram[8'h02] = 8'h7F;
      ram[8'h03] = "B"; ram[8'h04] = 8'h00;
      run_line(0, 8'h00);

      for (int r = 0; r < 6; r++) begin
         sa  = 8'($urandom);
         len = $urandom_range(24, 0);
         for (int j = 0; j < len; j++) ram[sa + 8'(j)] = 8'($urandom_range(255, 1));
         ram[sa + 8'(len)] = 8'h00;
         run_line(r % 2, sa);
      end

      for (int i = 0; i < 256; i++) ram[i] = 8'h78;
      run_line(0, 8'hF0);
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;

      // APPEND_CR=0 instance, with a second start issued mid-line.
      ram[8'h20] = "Z"; ram[8'h21] = 8'h00;
      ram[8'h10] = "H"; ram[8'h11] = "I"; ram[8'h12] = 8'h00;
      expect_line(1, 8'h20, 1'b0);
      issue_start(1, 8'h20);
      repeat (2) @(negedge clock);
      start1 = 1'b1; sa1 = 8'h10;
      @(negedge clock);
      start1 = 1'b0;
      wait_done(1);
      repeat (20) @(negedge clock);
      wait_uart_idle();

      // Reset while waiting on the second byte of HELLO.
      ram[8'h50] = "H"; ram[8'h51] = "E"; ram[8'h52] = "L";
      ram[8'h53] = "L"; ram[8'h54] = "O"; ram[8'h55] = 8'h00;
      uart_lo = 5; uart_hi = 8;
      expect_line(0, 8'h50, 1'b1);
      issue_start(0, 8'h50);
      cyc = 0;
      while (exp_q.size() > 5 && cyc < 2000) begin
         @(negedge clock);
         cyc++;
      end
      chk("hello_two_bytes_sent", exp_q.size(), 5);
      @(negedge clock);
      reset = 1'b1;
      exp_q.delete();
      done_q.delete();
      @(negedge clock);
      chk("abort_addr", int'(addr0), 0);
      chk("abort_tx_data", int'(txd0), 0);
      chk("abort_tx_start", int'(txs0), 0);
      chk("abort_busy", int'(busy0), 0);
      chk("abort_line_done", int'(lnd0), 0);
      @(negedge clock);
      reset = 1'b0;
      uart_lo = 1; uart_hi = 6;
      repeat (40) @(negedge clock);
      chk("abort_stays_idle", int'(busy0), 0);
      wait_uart_idle();
      run_line(0, 8'h50);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
